// File: rtl/usb_rx_byte_ctrl.sv
// rtl/usb_rx_byte_ctrl.sv - USB receive SYNC hunt, bit destuffing and byte framing controller
module usb_rx_byte_ctrl #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       eop,
    input  logic [7:0] sr_data,
    output logic       sr_shift,
    output logic       sr_bit,
    output logic       sr_restart,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       rx_active,
    output logic       rx_done,
    output logic       rx_error
);

    typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1, ERR = 2'd2} state_t;

    localparam logic [2:0] STUFF_LIMIT = 3'(STUFF_LEN);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic       sr_shift_q, sr_shift_d;
    logic       sr_bit_q, sr_bit_d;
    logic       sr_restart_q, sr_restart_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       byte_valid_q, byte_valid_d;
    logic       rx_active_q, rx_active_d;
    logic       rx_done_q, rx_done_d;
    logic       rx_error_q, rx_error_d;
    // Two-stage markers travel alongside each shift so sr_data is sampled once it settles.
    logic       p1_sync_q, p1_sync_d, p2_sync_q;
    logic       p1_byte_q, p1_byte_d, p2_byte_q;

    logic bit_ev, hunt_shift, data_accept, data_drop, stuff_err, sync_hit;

    always_comb begin
        bit_ev      = bit_valid && !eop;
        hunt_shift  = (state_q == HUNT) && bit_ev;
        data_accept = (state_q == DATA) && bit_ev && (ones_cnt_q != STUFF_LIMIT);
        data_drop   = (state_q == DATA) && bit_ev && (ones_cnt_q == STUFF_LIMIT) && !bit_in;
        stuff_err   = (state_q == DATA) && bit_ev && (ones_cnt_q == STUFF_LIMIT) && bit_in;
        sync_hit    = (state_q == HUNT) && p2_sync_q && (sr_data == SYNC_PATTERN);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= 3'd0;
            ones_cnt_q   <= 3'd0;
            sr_shift_q   <= 1'b0;
            sr_bit_q     <= 1'b0;
            sr_restart_q <= 1'b0;
            rx_byte_q    <= 8'h00;
            byte_valid_q <= 1'b0;
            rx_active_q  <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_error_q   <= 1'b0;
            p1_sync_q    <= 1'b0;
            p2_sync_q    <= 1'b0;
            p1_byte_q    <= 1'b0;
            p2_byte_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            sr_shift_q   <= sr_shift_d;
            sr_bit_q     <= sr_bit_d;
            sr_restart_q <= sr_restart_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            rx_active_q  <= rx_active_d;
            rx_done_q    <= rx_done_d;
            rx_error_q   <= rx_error_d;
            p1_sync_q    <= p1_sync_d;
            p2_sync_q    <= p1_sync_q;
            p1_byte_q    <= p1_byte_d;
            p2_byte_q    <= p1_byte_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        case (state_q)
            HUNT: begin
                if (sync_hit) begin
                    state_d    = DATA;
                    bit_cnt_d  = 3'd0;
                    ones_cnt_d = 3'd1;
                end
            end
            DATA: begin
                if (eop) begin
                    state_d    = HUNT;
                    bit_cnt_d  = 3'd0;
                    ones_cnt_d = 3'd0;
                end else if (stuff_err) begin
                    state_d = ERR;
                end else if (data_drop) begin
                    ones_cnt_d = 3'd0;
                end else if (data_accept) begin
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    ones_cnt_d = bit_in ? ones_cnt_q + 3'd1 : 3'd0;
                end
            end
            ERR: begin
                if (eop) begin
                    state_d    = HUNT;
                    bit_cnt_d  = 3'd0;
                    ones_cnt_d = 3'd0;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        sr_shift_d   = hunt_shift || data_accept;
        sr_bit_d     = (hunt_shift || data_accept) ? bit_in : sr_bit_q;
        sr_restart_d = eop;
        p1_sync_d    = hunt_shift;
        p1_byte_d    = data_accept && (bit_cnt_q == 3'd7);
        byte_valid_d = p2_byte_q;
        rx_byte_d    = p2_byte_q ? sr_data : rx_byte_q;
        rx_done_d    = (state_q == DATA) && eop && (bit_cnt_q == 3'd0);
        rx_error_d   = ((state_q == DATA) && eop && (bit_cnt_q != 3'd0)) || stuff_err;
        rx_active_d  = rx_active_q;
        if (sync_hit)
            rx_active_d = 1'b1;
        if (eop || stuff_err)
            rx_active_d = 1'b0;
    end

    assign sr_shift   = sr_shift_q;
    assign sr_bit     = sr_bit_q;
    assign sr_restart = sr_restart_q;
    assign rx_byte    = rx_byte_q;
    assign byte_valid = byte_valid_q;
    assign rx_active  = rx_active_q;
    assign rx_done    = rx_done_q;
    assign rx_error   = rx_error_q;

endmodule

// File: tb/tb_usb_rx_byte_ctrl.sv
// tb/tb_usb_rx_byte_ctrl.sv - directed and random bench with a packet-level reference model
module tb_usb_rx_byte_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       eop = 1'b0;
    logic [7:0] sr_data;
    logic       sr_shift, sr_bit, sr_restart, byte_valid, rx_active, rx_done, rx_error;
    logic [7:0] rx_byte;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External LSB-first shift register: first arriving bit ends in bit 0.
    logic [7:0] sr_q = 8'h00;
    always @(posedge clk) begin
        if (sr_restart)
            sr_q <= 8'h00;
        else if (sr_shift)
            sr_q <= {sr_bit, sr_q[7:1]};
    end
    assign sr_data = sr_q;

    usb_rx_byte_ctrl dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .eop        (eop),
        .sr_data    (sr_data),
        .sr_shift   (sr_shift),
        .sr_bit     (sr_bit),
        .sr_restart (sr_restart),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .rx_active  (rx_active),
        .rx_done    (rx_done),
        .rx_error   (rx_error)
    );

    // Reference model: packet receiver described by its rules, not by its registers.
    int         m_mode = 0;  // 0 hunting, 1 in packet, 2 waiting for eop after error
    logic [7:0] m_hist = 8'h00;
    int         m_nbits = 0;
    int         m_ones = 0;
    logic       m_active = 1'b0;
    logic [7:0] m_last = 8'h00;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_nbits = 0; m_ones = 0; m_active = 1'b0; m_last = 8'h00;
    endtask

    task automatic ev(input bit is_eop, input bit has_bit, input bit b);
        bit e_shift, e_restart, e_done, e_err, e_bv, e_act1;
        e_shift = 0; e_restart = 0; e_done = 0; e_err = 0; e_bv = 0;
        e_act1 = m_active;
        if (is_eop) begin
            e_restart = 1;
            if (m_mode == 1) begin
                if (m_nbits % 8 == 0) e_done = 1; else e_err = 1;
            end
            m_mode = 0; m_active = 0; e_act1 = 0;
            m_hist = 8'h00; m_nbits = 0; m_ones = 0;
        end else if (has_bit) begin
            if (m_mode == 0) begin
                e_shift = 1;
                m_hist = {b, m_hist[7:1]};
                if (m_hist == 8'h80) begin
                    m_mode = 1; m_active = 1; m_nbits = 0; m_ones = 1;
                end
            end else if (m_mode == 1) begin
                if (m_ones == 6) begin
                    if (b) begin
                        e_err = 1; m_active = 0; e_act1 = 0; m_mode = 2;
                    end else begin
                        m_ones = 0;
                    end
                end else begin
                    e_shift = 1;
                    m_hist = {b, m_hist[7:1]};
                    m_nbits++;
                    m_ones = b ? m_ones + 1 : 0;
                    if (m_nbits % 8 == 0) begin
                        e_bv = 1; m_last = m_hist;
                    end
                end
            end
        end

        @(posedge clk); #1;
        eop = is_eop; bit_valid = has_bit; bit_in = b;
        @(posedge clk); #1;
        eop = 1'b0; bit_valid = 1'b0;
        chk("t1_shift", 16'(sr_shift), 16'(e_shift));
        if (e_shift)
            chk("t1_sr_bit", 16'(sr_bit), 16'(b));
        chk("t1_restart", 16'(sr_restart), 16'(e_restart));
        chk("t1_done", 16'(rx_done), 16'(e_done));
        chk("t1_error", 16'(rx_error), 16'(e_err));
        chk("t1_active", 16'(rx_active), 16'(e_act1));
        chk("t1_byte_valid", 16'(byte_valid), 16'd0);
        @(posedge clk); #1;
        chk("t2_quiet", 16'({sr_shift, sr_restart, byte_valid, rx_done, rx_error}), 16'd0);
        @(posedge clk); #1;
        chk("t3_byte_valid", 16'(byte_valid), 16'(e_bv));
        chk("t3_rx_byte", 16'(rx_byte), 16'(m_last));
        chk("t3_active", 16'(rx_active), 16'(m_active));
        chk("t3_quiet", 16'({sr_shift, sr_restart, rx_done, rx_error}), 16'd0);
    endtask

    task automatic send_bit(input bit b);
        ev(1'b0, 1'b1, b);
    endtask

    task automatic send_eop();
        ev(1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {1'b0, sr_shift, sr_bit, sr_restart, rx_byte, byte_valid, rx_active, rx_done, rx_error}, 16'd0);
    endtask

    initial begin
        #3;
        check_all_zero("reset_outputs");
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_all_zero("post_reset_quiet");
        end

        // Noise, SYNC, 0xA5, clean EOP
        send_bit(1); send_bit(1); send_bit(0);
        send_sync();
        send_byte(8'hA5);
        send_eop();

        // Stuffed zero after six ones is dropped
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1);
        send_bit(0);
        for (int i = 0; i < 3; i++) send_bit(1);
        chk("stuff_byte", 16'(rx_byte), 16'h00FF);
        send_eop();

        // Stuff error, ignored bits, then EOP recovery
        send_sync();
        for (int i = 0; i < 6; i++) send_bit(1);
        send_bit(1); send_bit(0);
        send_eop();

        // EOP mid-byte, then a fresh packet
        send_sync();
        send_bit(1); send_bit(0); send_bit(1);
        send_eop();
        send_sync();
        send_byte(8'h3C);
        send_eop();

        // Asynchronous reset mid-packet
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(posedge clk); #3;
        n_rst = 1'b0;
        #1;
        check_all_zero("midpkt_reset");
        model_reset();
        @(posedge clk); #2 n_rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midpkt_release");
        send_sync();
        send_byte(8'h01);
        chk("after_reset_byte", 16'(rx_byte), 16'h0001);
        send_eop();

        // Simultaneous eop and bit_valid
        send_sync();
        ev(1'b1, 1'b1, 1'b1);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6)
                send_eop();
            else if (r < 9)
                ev(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            else if (r < 20)
                send_sync();
            else
                send_bit($urandom_range(0, 9) < 7);
        end
        send_eop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
